// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue slice:
// opcodes, alu_ctrl codes and the issue FSM state type.
package alu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } state_t;

endpackage

// File: rtl/alu_issue_unit_alu.sv
// Combinational RV32I integer ALU.
// Ports: i_a, i_b operands, i_ctrl alu_ctrl code, o_y result.
module alu_issue_unit_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_ctrl,
  output logic [WIDTH-1:0] o_y
);

  logic [4:0] w_sh;
  logic       w_lt;
  logic       w_ltu;

  assign w_sh  = i_b[4:0];
  assign w_lt  = $signed(i_a) < $signed(i_b);
  assign w_ltu = i_a < i_b;

  always_comb begin
    o_y = '0;
    case (i_ctrl)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_SLL:  o_y = i_a << w_sh;
      ALU_SLT:  o_y = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLTU: o_y = {{(WIDTH-1){1'b0}}, w_ltu};
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SRL:  o_y = i_a >> w_sh;
      ALU_SRA:  o_y = $unsigned($signed(i_a) >>> w_sh);
      ALU_OR:   o_y = i_a | i_b;
      ALU_AND:  o_y = i_a & i_b;
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Single-entry OP/OP-IMM issue slot: decodes, executes and holds one result.
// Ports: in_* upstream valid/ready + instr/operands, out_* downstream result.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_zero,
  output logic             out_illegal
);

  state_t r_state;
  state_t w_next;

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [WIDTH-1:0] w_imm;
  logic [WIDTH-1:0] w_b;
  logic [3:0]       w_ctrl;
  logic             w_ill;
  logic [WIDTH-1:0] w_alu_y;
  logic [WIDTH-1:0] w_res;
  logic             w_in_xfer;
  logic             w_out_xfer;

  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_rd;
  logic             r_zero;
  logic             r_illegal;

  assign w_opc = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_f7  = in_instr[31:25];
  assign w_imm = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};

  always_comb begin
    w_ill  = 1'b1;
    w_ctrl = ALU_ADD;
    w_b    = in_rs2;
    unique case (1'b1)
      (w_opc == OPC_OP): begin
        w_ctrl = {w_f7[5], w_f3};
        w_ill  = !((w_f7 == F7_BASE) ||
                   ((w_f7 == F7_ALT) &&
                    ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      (w_opc == OPC_OPIMM): begin
        w_b    = w_imm;
        // Only the shift-right immediate carries a mode bit in funct7.
        w_ctrl = (w_f3 == 3'b101) ? {w_f7[5], w_f3} : {1'b0, w_f3};
        w_ill  = ((w_f3 == 3'b001) && (w_f7 != F7_BASE)) ||
                 ((w_f3 == 3'b101) && (w_f7 != F7_BASE) &&
                  (w_f7 != F7_ALT));
      end
      default: w_ill = 1'b1;
    endcase
  end

  alu_issue_unit_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a    (in_rs1),
    .i_b    (w_b),
    .i_ctrl (w_ctrl),
    .o_y    (w_alu_y)
  );

  assign w_res      = w_ill ? '0 : w_alu_y;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_in_xfer) w_next = S_FULL;
      S_FULL: if (w_out_xfer && !w_in_xfer) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == S_FULL);
    in_ready  = (r_state == S_IDLE) || out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result  <= '0;
      r_rd      <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_in_xfer) begin
      r_result  <= w_res;
      r_rd      <= in_instr[11:7];
      r_zero    <= (w_res == '0);
      r_illegal <= w_ill;
    end
  end

  assign out_result  = r_result;
  assign out_rd      = r_rd;
  assign out_zero    = r_zero;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed + randomized bench for alu_issue_unit.
// Reference model works from RV32I mnemonics, not alu_ctrl codes.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_zero;
  logic        out_illegal;

  int n_pass = 0;
  int n_total = 0;

  // model state: one held result, plus "cleared by reset" flag
  logic        m_valid = 1'b0;
  logic        m_clear = 1'b0;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  logic        m_ill;

  always #5 clk = ~clk;

  alu_issue_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7,
                                     input logic [4:0] r2,
                                     input logic [2:0] f3,
                                     input logic [4:0] rd,
                                     input logic [6:0] opc);
    return {f7, r2, 5'd1, f3, rd, opc};
  endfunction

  function automatic void ref_model(input  logic [31:0] ins,
                                    input  logic [31:0] a,
                                    input  logic [31:0] r2,
                                    output logic        ill,
                                    output logic [31:0] res);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] b;
    int          sh;
    bit          is_op;
    bit          is_imm;
    opc    = ins[6:0];
    f3     = ins[14:12];
    f7     = ins[31:25];
    is_op  = (opc == 7'b0110011);
    is_imm = (opc == 7'b0010011);
    b      = is_op ? r2 : {{20{ins[31]}}, ins[31:20]};
    sh     = int'(b[4:0]);
    if (is_op)
      ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
    else if (is_imm)
      ill = (f3 == 1 && f7 != 7'h00) ||
            (f3 == 5 && f7 != 7'h00 && f7 != 7'h20);
    else
      ill = 1'b1;
    case (f3)
      3'd0: res = (is_op && f7 == 7'h20) ? a - b : a + b;
      3'd1: res = a << sh;
      3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: res = (a < b) ? 32'd1 : 32'd0;
      3'd4: res = a ^ b;
      3'd5: res = f7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    if (ill) res = 32'd0;
  endfunction

  task automatic check_outs();
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("out_result", out_result, m_res);
      check("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
      check("out_zero", {31'd0, out_zero}, {31'd0, m_res == 0});
      check("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
    end else if (m_clear) begin
      check("rst_result", out_result, 32'd0);
      check("rst_rd", {27'd0, out_rd}, 32'd0);
      check("rst_zero", {31'd0, out_zero}, 32'd0);
      check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    end
  endtask

  // One cycle: drive, check ready, clock, update model, check outputs.
  task automatic step(input logic        v,
                      input logic [31:0] ins,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic        ordy,
                      input logic        rst);
    logic        exp_rdy;
    logic        ill;
    logic [31:0] res;
    reset     = rst;
    in_valid  = v;
    in_instr  = ins;
    in_rs1    = a;
    in_rs2    = b;
    out_ready = ordy;
    exp_rdy   = !m_valid || ordy;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_clear = 1'b1;
    end else if (v && exp_rdy) begin
      ref_model(ins, a, b, ill, res);
      m_valid = 1'b1;
      m_clear = 1'b0;
      m_res   = res;
      m_rd    = ins[11:7];
      m_ill   = ill;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_outs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: opc = 7'b0110011;
      4, 5, 6, 7: opc = 7'b0010011;
      8:          opc = 7'b0000011;
      default:    opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, r[24:7], opc};
  endfunction

  logic [31:0] w_add;
  logic [31:0] w_held;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_rs1 = '0;
    in_rs2 = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);

    w_add = mk(7'h00, 5'd2, 3'b000, 5'd5, 7'b0110011);
    step(1, w_add, 32'h7FFF_FFFF, 32'd1, 1, 0);
    check("add_wrap", out_result, 32'h8000_0000);
    check("add_rd", {27'd0, out_rd}, 32'd5);

    step(1, mk(7'h20, 5'd4, 3'b101, 5'd3, 7'b0010011),
         32'h8000_0000, 0, 1, 0);
    check("srai", out_result, 32'hF800_0000);
    step(1, mk(7'h00, 5'd4, 3'b101, 5'd3, 7'b0010011),
         32'h8000_0000, 0, 1, 0);
    check("srli", out_result, 32'h0800_0000);

    step(1, mk(7'h00, 5'd2, 3'b010, 5'd7, 7'b0110011),
         32'hFFFF_FFFF, 32'd1, 1, 0);
    check("slt", out_result, 32'd1);
    step(1, mk(7'h00, 5'd2, 3'b011, 5'd7, 7'b0110011),
         32'hFFFF_FFFF, 32'd1, 1, 0);
    check("sltu", out_result, 32'd0);
    step(1, mk(7'h20, 5'd2, 3'b000, 5'd9, 7'b0110011),
         32'd5, 32'd5, 0, 0);
    check("sub_zero_res", out_result, 32'd0);
    check("sub_zero_flag", {31'd0, out_zero}, 32'd1);

    // stall three cycles with new work offered, then stream
    w_held = out_result;
    for (int i = 0; i < 3; i++) begin
      step(1, w_add, 32'd1, 32'd1, 0, 0);
      check("stall_hold", out_result, w_held);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, w_add, 32'(i * 10), 32'd3, 1, 0);
      check("b2b", out_result, 32'(i * 10 + 3));
    end

    step(1, mk(7'h00, 5'd2, 3'b000, 5'd4, 7'b0000011),
         32'd9, 32'd9, 1, 0);
    check("load_illegal", {31'd0, out_illegal}, 32'd1);
    step(1, mk(7'h01, 5'd2, 3'b000, 5'd4, 7'b0110011),
         32'd9, 32'd9, 1, 0);
    check("mul_illegal", {31'd0, out_illegal}, 32'd1);
    check("mul_result", out_result, 32'd0);

    step(1, w_add, 32'd1, 32'd2, 0, 0);
    step(1, w_add, 32'd1, 32'd2, 0, 1);
    check("rst_full", {31'd0, out_valid}, 32'd0);
    check("rst_full_res", out_result, 32'd0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
